// File: rtl/l2_cache_miss_responder_if.sv
// Bus bundle for the L2 miss responder: enqueue port from the miss pipeline,
// the memory read channel, and the fill port to the L2 pipeline arbiter.
// The slave modport is the responder's view. The master modport is the view of
// the surrounding system (miss pipeline, memory and arbiter).
interface l2_cache_miss_responder_if #(
  parameter int TAG_WIDTH = 8
);
  // Enqueue side
  logic                 enqueue_valid;
  logic [25:0]          enqueue_address;
  logic                 enqueue_duplicate;
  logic [TAG_WIDTH-1:0] enqueue_tag;
  logic                 queue_full;
  // Memory read channel
  logic                 mem_req;
  logic [31:0]          mem_address;
  logic                 mem_ack;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;
  // Fill side
  logic                 fill_valid;
  logic [25:0]          fill_address;
  logic [TAG_WIDTH-1:0] fill_tag;
  logic [511:0]         fill_data;
  logic                 fill_is_duplicate;
  logic                 fill_ack;

  modport master (
    output enqueue_valid, enqueue_address, enqueue_duplicate, enqueue_tag,
    input  queue_full,
    input  mem_req, mem_address,
    output mem_ack, mem_rvalid, mem_rdata,
    input  fill_valid, fill_address, fill_tag, fill_data, fill_is_duplicate,
    output fill_ack
  );

  modport slave (
    input  enqueue_valid, enqueue_address, enqueue_duplicate, enqueue_tag,
    output queue_full,
    output mem_req, mem_address,
    input  mem_ack, mem_rvalid, mem_rdata,
    output fill_valid, fill_address, fill_tag, fill_data, fill_is_duplicate,
    input  fill_ack
  );
endinterface

// File: rtl/l2_cache_miss_responder.sv
// L2 cache miss responder.
// Misses are queued in a FIFO. The head entry is fetched from memory as one
// 16-beat, 32-bit burst that forms a 64-byte line. The line is then offered to
// the L2 pipeline as a fill request. The entry pops when the arbiter
// acknowledges the fill.
// Optional feature: when L2_DUPLICATE_BYPASS_EN is defined, a head entry that
// is flagged as a duplicate skips the memory fetch. It is presented directly
// as a fill with fill_is_duplicate set and zero data.
module l2_cache_miss_responder #(
  parameter int QUEUE_SIZE = 8,
  parameter int TAG_WIDTH  = 8
) (
  input logic                     clk,
  input logic                     reset_n,
  l2_cache_miss_responder_if.slave bus
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_FILL
  } state_e;

  // Miss queue storage
  logic [25:0]          q_addr [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] q_tag  [QUEUE_SIZE];
`ifdef L2_DUPLICATE_BYPASS_EN
  logic                 q_dup  [QUEUE_SIZE];
`endif

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             queue_full;
  logic             push, pop;

  // FSM and datapath state
  state_e               state_q, state_d;
  logic                 latch_head;
  logic                 beat_en;
  logic [3:0]           beat_q;
  logic [25:0]          head_addr_q;
  logic [TAG_WIDTH-1:0] head_tag_q;
  logic [511:0]         line_q;
`ifdef L2_DUPLICATE_BYPASS_EN
  logic                 head_dup_q;
  logic                 bypass;
`else
  logic                 unused_dup;
  assign unused_dup = bus.enqueue_duplicate;
`endif

  assign queue_full = (count_q == CNT_W'(QUEUE_SIZE));
  assign push       = bus.enqueue_valid && !queue_full;

  // Queue storage write. The payload is only read after a push, so it has no reset.
  // NOTE: memories are left out of reset so that they can map onto RAM;
  // occupancy and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr_q] <= bus.enqueue_address;
      q_tag[wr_ptr_q]  <= bus.enqueue_tag;
`ifdef L2_DUPLICATE_BYPASS_EN
      q_dup[wr_ptr_q]  <= bus.enqueue_duplicate;
`endif
    end
  end

  // Pointers wrap naturally because QUEUE_SIZE is a power of two. A push and
  // a pop in the same cycle leave the occupancy unchanged.
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples values from before the edge, regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state and control strobes
  // NOTE: every output of this block gets a default value first. An incomplete
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    latch_head = 1'b0;
    beat_en    = 1'b0;
    pop        = 1'b0;
`ifdef L2_DUPLICATE_BYPASS_EN
    bypass     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          latch_head = 1'b1;
`ifdef L2_DUPLICATE_BYPASS_EN
          if (q_dup[rd_ptr_q]) begin
            bypass  = 1'b1;
            state_d = S_FILL;
          end else begin
            state_d = S_REQ;
          end
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (bus.mem_ack) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus.mem_rvalid) begin
          beat_en = 1'b1;
          if (beat_q == 4'd15) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.fill_ack) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Head entry capture and beat counter. The counter restarts with each new
  // head, so beats left over from an abandoned burst cannot misplace data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_addr_q <= '0;
      head_tag_q  <= '0;
      beat_q      <= '0;
`ifdef L2_DUPLICATE_BYPASS_EN
      head_dup_q  <= 1'b0;
`endif
    end else begin
      if (latch_head) begin
        head_addr_q <= q_addr[rd_ptr_q];
        head_tag_q  <= q_tag[rd_ptr_q];
`ifdef L2_DUPLICATE_BYPASS_EN
        head_dup_q  <= q_dup[rd_ptr_q];
`endif
        beat_q      <= '0;
      end else if (beat_en) begin
        beat_q <= beat_q + 4'd1;
      end
    end
  end

  // Line buffer: beat n lands in bits [32n+31:32n]. It is fully rewritten
  // before every fill, so it has no reset.
  always_ff @(posedge clk) begin
`ifdef L2_DUPLICATE_BYPASS_EN
    if (bypass) line_q <= '0;
    else if (beat_en) line_q[{beat_q, 5'b0} +: 32] <= bus.mem_rdata;
`else
    if (beat_en) line_q[{beat_q, 5'b0} +: 32] <= bus.mem_rdata;
`endif
  end

  assign bus.queue_full   = queue_full;
  assign bus.mem_req      = (state_q == S_REQ);
  assign bus.mem_address  = {head_addr_q, 6'b0};
  assign bus.fill_valid   = (state_q == S_FILL);
  assign bus.fill_address = head_addr_q;
  assign bus.fill_tag     = head_tag_q;
  assign bus.fill_data    = line_q;
`ifdef L2_DUPLICATE_BYPASS_EN
  assign bus.fill_is_duplicate = (state_q == S_FILL) && head_dup_q;
`else
  assign bus.fill_is_duplicate = 1'b0;
`endif

`ifndef SYNTHESIS
  // An enqueue while full is dropped. The upstream stall should prevent it.
  a_enqueue_when_full: assert property (
    @(posedge clk) disable iff (!reset_n) !(bus.enqueue_valid && queue_full)
  ) else $warning("enqueue dropped: miss queue is full");
`endif

endmodule

// File: tb/tb_l2_cache_miss_responder.sv
// Directed self-checking bench for l2_cache_miss_responder.
// It covers reset values, the minimum-latency miss, fill hold under
// back-pressure, duplicate handling, queue full with a dropped enqueue, a
// simultaneous enqueue and pop, and reset in the middle of a burst.
module tb_l2_cache_miss_responder;

  localparam int QS = 8;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  l2_cache_miss_responder_if #(.TAG_WIDTH(TW)) bus ();

  l2_cache_miss_responder #(.QUEUE_SIZE(QS), .TAG_WIDTH(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [25:0] a, input logic [7:0] t, input logic d);
    bus.enqueue_valid     = 1'b1;
    bus.enqueue_address   = a;
    bus.enqueue_tag       = t;
    bus.enqueue_duplicate = d;
    step();
    bus.enqueue_valid     = 1'b0;
    bus.enqueue_duplicate = 1'b0;
  endtask

  // Serves one miss as memory and arbiter, and checks the request and the fill.
  // lat counts the cycles from the call until fill_valid is first seen.
  task automatic serve(input logic [25:0] a, input logic [7:0] t, input logic [31:0] base,
                       input int hold, input bit enq_on_ack, input logic [25:0] ea,
                       input logic [7:0] et, output int lat_o);
    int cyc;
    logic [511:0] exp_line;
    cyc = 0;
    exp_line = '0;
    while (bus.mem_req !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    check("mem_req_seen", bus.mem_req, 1'b1);
    check("mem_address", bus.mem_address, {a, 6'b0});
    // Ack immediately, with a stray beat that must be ignored outside DATA.
    bus.mem_ack    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    step();
    cyc++;
    bus.mem_ack = 1'b0;
    check("mem_req_drop", bus.mem_req, 1'b0);
    for (int n = 0; n < 16; n++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + 32'(n);
      exp_line[32*n +: 32] = base + 32'(n);
      step();
      cyc++;
    end
    bus.mem_rvalid = 1'b0;
    lat_o = cyc;
    check("fill_valid", bus.fill_valid, 1'b1);
    check("fill_address", bus.fill_address, a);
    check("fill_tag", bus.fill_tag, t);
    check("fill_data", bus.fill_data, exp_line);
    check("fill_is_dup", bus.fill_is_duplicate, 1'b0);
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", bus.fill_valid, 1'b1);
      check("hold_data", bus.fill_data, exp_line);
      check("hold_addr", bus.fill_address, a);
      check("hold_tag", bus.fill_tag, t);
      check("hold_no_req", bus.mem_req, 1'b0);
    end
    bus.fill_ack = 1'b1;
    if (enq_on_ack) begin
      bus.enqueue_valid   = 1'b1;
      bus.enqueue_address = ea;
      bus.enqueue_tag     = et;
    end
    step();
    bus.fill_ack      = 1'b0;
    bus.enqueue_valid = 1'b0;
    check("fill_valid_drop", bus.fill_valid, 1'b0);
  endtask

  initial begin
    bus.enqueue_valid     = 1'b0;
    bus.enqueue_address   = '0;
    bus.enqueue_duplicate = 1'b0;
    bus.enqueue_tag       = '0;
    bus.mem_ack           = 1'b0;
    bus.mem_rvalid        = 1'b0;
    bus.mem_rdata         = '0;
    bus.fill_ack          = 1'b0;
    reset_n               = 1'b0;

    // Reset values
    #2;
    check("rst_queue_full", bus.queue_full, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_fill_valid", bus.fill_valid, 1'b0);
    check("rst_fill_dup", bus.fill_is_duplicate, 1'b0);
    check("rst_mem_address", bus.mem_address, 32'h0);
    check("rst_fill_address", bus.fill_address, 26'h0);
    check("rst_fill_tag", bus.fill_tag, 8'h0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Minimum-latency miss: 26'h123 gives byte address 32'h48C0 and a fill after
    // 18 cycles. The fill is then held for 5 cycles without an ack.
    enq(26'h0000123, 8'h5A, 1'b0);
    serve(26'h0000123, 8'h5A, 32'h1000, 5, 1'b0, '0, '0, lat);
    check("latency", 32'(lat), 32'd18);
    check("mem_address_48c0", {dut.head_addr_q, 6'b0}, 32'h0000_48C0);
    repeat (3) step();
    check("empty_no_req", bus.mem_req, 1'b0);

    // Duplicate miss
`ifdef L2_DUPLICATE_BYPASS_EN
    begin
      bit saw_req;
      int cyc;
      saw_req = 1'b0;
      cyc = 0;
      enq(26'h10, 8'h11, 1'b1);
      while (bus.fill_valid !== 1'b1 && cyc < 10) begin
        if (bus.mem_req === 1'b1) saw_req = 1'b1;
        step();
        cyc++;
      end
      check("dup_no_mem_req", saw_req, 1'b0);
      check("dup_fill_valid", bus.fill_valid, 1'b1);
      check("dup_flag", bus.fill_is_duplicate, 1'b1);
      check("dup_fill_address", bus.fill_address, 26'h10);
      check("dup_fill_data", bus.fill_data, 512'h0);
      bus.fill_ack = 1'b1;
      step();
      bus.fill_ack = 1'b0;
      check("dup_fill_drop", bus.fill_valid, 1'b0);
    end
`else
    enq(26'h10, 8'h11, 1'b1);
    serve(26'h10, 8'h11, 32'h7000, 0, 1'b0, '0, '0, lat);
`endif

    // Queue full with memory stalled. The 9th enqueue is dropped.
    for (int i = 0; i < 7; i++) enq(26'h200 + 26'(i), 8'(i), 1'b0);
    check("not_full_at_7", bus.queue_full, 1'b0);
    enq(26'h207, 8'h07, 1'b0);
    check("full_at_8", bus.queue_full, 1'b1);
    enq(26'h3FF, 8'hFF, 1'b0);
    check("full_after_drop", bus.queue_full, 1'b1);
    check("stall_mem_req", bus.mem_req, 1'b1);
    check("stall_mem_address", bus.mem_address, 32'h0000_8000);

    // Drain entries 0..4. Entry 5 is acked in the same cycle as a new enqueue.
    for (int i = 0; i < 5; i++) begin
      serve(26'h200 + 26'(i), 8'(i), 32'h2000 + 32'(i * 256), 0, 1'b0, '0, '0, lat);
      if (i == 0) check("full_clears", bus.queue_full, 1'b0);
    end
    serve(26'h205, 8'h05, 32'h2500, 0, 1'b1, 26'h0ABC, 8'hAB, lat);
    serve(26'h206, 8'h06, 32'h2600, 0, 1'b0, '0, '0, lat);
    serve(26'h207, 8'h07, 32'h2700, 0, 1'b0, '0, '0, lat);
    serve(26'h0ABC, 8'hAB, 32'h3000, 0, 1'b0, '0, '0, lat);
    repeat (10) step();
    check("drained_no_req", bus.mem_req, 1'b0);

    // Reset after beat 7 of a burst. Stale beats arriving after the release
    // must be ignored.
    enq(26'h155, 8'h33, 1'b0);
    begin
      int cyc;
      cyc = 0;
      while (bus.mem_req !== 1'b1 && cyc < 10) begin
        step();
        cyc++;
      end
    end
    check("mb_mem_req", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    for (int n = 0; n < 8; n++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hBAD0 + 32'(n);
      step();
    end
    reset_n = 1'b0;
    #1;
    check("mb_rst_mem_req", bus.mem_req, 1'b0);
    check("mb_rst_fill_valid", bus.fill_valid, 1'b0);
    check("mb_rst_mem_address", bus.mem_address, 32'h0);
    step();
    reset_n = 1'b1;
    for (int n = 8; n < 12; n++) begin
      bus.mem_rdata = 32'hBAD0 + 32'(n);
      step();
    end
    bus.mem_rvalid = 1'b0;
    check("mb_after_no_req", bus.mem_req, 1'b0);
    check("mb_after_no_fill", bus.fill_valid, 1'b0);
    enq(26'h2AA, 8'h77, 1'b0);
    serve(26'h2AA, 8'h77, 32'h5000, 0, 1'b0, '0, '0, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_cache_miss_responder.md
L2_CACHE_MISS_RESPONDER -- requirements
Module: l2_cache_miss_responder

Interface
REQ-001 Parameter QUEUE_SIZE, default 8: miss-queue depth in entries; power of two, 2..64.
REQ-002 Parameter TAG_WIDTH, default 8: width of the opaque request tag carried from enqueue to fill.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port enqueue_valid  input  1  an L2 miss is presented this cycle.
REQ-006 Port enqueue_address  input  26  cache-line address, byte address bits [31:6].
REQ-007 Port enqueue_duplicate  input  1  line already pending, from the pending-miss tracker.
REQ-008 Port enqueue_tag  input  TAG_WIDTH  opaque request tag.
REQ-009 Port queue_full  output  1  no free entry; the upstream pipeline stalls.
REQ-010 Port mem_req  output  1  memory read request, held until acknowledged.
REQ-011 Port mem_address  output  32  byte address {line,6'b0}.
REQ-012 Port mem_ack  input  1  memory accepted the request.
REQ-013 Port mem_rvalid  input  1  one 32-bit read beat is valid.
REQ-014 Port mem_rdata  input  32  read beat data.
REQ-015 Port fill_valid  output  1  restarted fill request presented to the L2 pipeline arbiter.
REQ-016 Port fill_address / fill_tag / fill_data  output  26 / TAG_WIDTH / 512  fill contents.
REQ-017 Port fill_is_duplicate  output  1  fill carries no fetched data.
REQ-018 Port fill_ack  input  1  arbiter accepted the fill this cycle.

Function
REQ-019 The miss queue SHALL be a FIFO storing address, tag and duplicate flag; an entry is written when enqueue_valid is high and queue_full is low.
REQ-020 queue_full SHALL be high exactly when the occupancy count equals QUEUE_SIZE; an enqueue while full SHALL be dropped and flagged by a simulation assertion.
REQ-021 The FSM SHALL have four states: IDLE, REQ, DATA and FILL.
REQ-022 IDLE->REQ when the queue is non-empty; entering REQ also latches the head entry.
REQ-023 REQ: mem_req is high and mem_address is {head line,6'b0}; the FSM moves to DATA on the cycle mem_ack is high.
REQ-024 DATA: a 4-bit beat counter accepts mem_rdata on each mem_rvalid into bits [32*n+31:32*n] of the line buffer, beat 0 first.
REQ-025 DATA->FILL occurs on the 16th beat; mem_rvalid in any state other than DATA SHALL be ignored.
REQ-026 FILL: fill_valid is high and the fill outputs hold stable until fill_ack; the queue pops on fill_ack.
REQ-027 FILL->IDLE on fill_ack.
REQ-028 If fill_ack arrives in the same cycle as a new enqueue, the occupancy count SHALL stay unchanged and both the pop and the write SHALL complete.
REQ-029 The read and write pointers SHALL wrap modulo QUEUE_SIZE.
REQ-030 Latency: minimum from enqueue to fill_valid SHALL be 1 (IDLE) + 1 (REQ, mem_ack same cycle) + 16 beats = 18 cycles.
REQ-031 fill_valid SHALL be high only in state FILL.
REQ-032 mem_req SHALL be high only in state REQ.

Reset
REQ-033 When reset_n is low, asynchronously: FSM=IDLE; pointers, occupancy and beat counter=0.
REQ-034 During reset: queue_full=0, mem_req=0, fill_valid=0, fill_is_duplicate=0, mem_address=0, fill_address=0, fill_tag=0.
REQ-035 fill_data and the queue storage SHALL need no reset.
REQ-036 Reset asserted mid-burst SHALL abandon the transaction; beats arriving after reset is released SHALL be ignored until the next REQ.

Configuration
REQ-037 The macro L2_DUPLICATE_BYPASS_EN SHALL control duplicate handling.
REQ-038 With L2_DUPLICATE_BYPASS_EN defined, a head entry with its duplicate flag set SHALL go IDLE->FILL directly, with no memory access, fill_is_duplicate=1 and fill_data=0.
REQ-039 Without L2_DUPLICATE_BYPASS_EN, duplicates SHALL be fetched like any other miss, and fill_is_duplicate SHALL be tied to 0.

Verification
REQ-040 After reset, enqueue addr 26'h0000123, tag 8'h5A; memory acks immediately and returns beats 0..15 with values 32'h1000+n -> mem_address=32'h000048C0, fill_valid at cycle 18, fill_data word n = 32'h1000+n, fill_tag=8'h5A.
REQ-041 QUEUE_SIZE=8, memory stalled (no mem_ack), 8 enqueues -> queue_full=1 after the 8th; a 9th enqueue is dropped with the assertion firing; mem_req stays high with the first address.
REQ-042 Enqueue and fill_ack in the same cycle with 3 entries queued -> occupancy stays 3; the next REQ uses the second-oldest address.
REQ-043 L2_DUPLICATE_BYPASS_EN defined, enqueue addr 26'h10 with enqueue_duplicate=1 -> mem_req never asserts; fill_valid appears 1 cycle after leaving IDLE with fill_is_duplicate=1 and fill_address=26'h10.
REQ-044 Drive reset_n low after beat 7 of a burst, release, then enqueue a new miss -> fill_data contains only the new burst; the stale beats are ignored.
REQ-045 Hold fill_ack low for 5 cycles in FILL -> fill_valid and all fill outputs stay stable; the queue does not pop.
